// File: rtl/fp_pkg.sv
// Shared single-precision constants and the S1->S2 pipeline payload
// for the divider round/pack back end.
package fp_pkg;

  localparam int FP_BIAS    = 127;
  localparam int FP_EXP_MAX = 255;
  localparam logic [31:0] FP_QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] FP_POS_INF = 32'h7F80_0000;

  localparam int FP_SIG_W   = 24;  // significand incl. hidden bit
  localparam int FP_FRAC_W  = 23;
  localparam int FP_EXP_W   = 8;
  localparam int IN_EXP_W   = 10;
  localparam int IN_MANT_W  = 28;
  localparam int EXP_W      = IN_EXP_W + 1;  // headroom for +/-1 adjustments

  typedef struct packed {
    logic                 sign;
    logic [EXP_W-1:0]     exp;
    logic [FP_SIG_W-1:0]  sig;
    logic                 carry;
    logic                 inexact;
    logic                 nan;
    logic                 zero_div;
    logic                 inf;
    logic                 zero;
  } s1_t;

endpackage

// File: rtl/fp_rne_round.sv
// Round-to-nearest-even increment on a 24-bit significand.
module fp_rne_round
  import fp_pkg::*;
(
  input  logic [FP_SIG_W-1:0] sig_i,
  input  logic                guard_i,
  input  logic                sticky_i,
  output logic [FP_SIG_W-1:0] sig_o,
  output logic                carry_o,
  output logic                inexact_o
);

  logic inc;

  assign inc                = guard_i & (sticky_i | sig_i[0]);
  assign {carry_o, sig_o}   = {1'b0, sig_i} + {{FP_SIG_W{1'b0}}, inc};
  assign inexact_o          = guard_i | sticky_i;

endmodule

// File: rtl/fp_round_pack.sv
// Two-stage normalise/round (S1) and renormalise/range-check/pack (S2)
// back end for the FP divider, with valid/ready flow control.
module fp_round_pack
  import fp_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_sign,
  input  logic [IN_EXP_W-1:0]  in_exp,
  input  logic [IN_MANT_W-1:0] in_mant,
  input  logic                 in_sticky,
  input  logic                 in_nan,
  input  logic                 in_inf,
  input  logic                 in_zero,
  input  logic                 in_zero_div,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_result,
  output logic                 out_overflow,
  output logic                 out_underflow,
  output logic                 out_inexact,
  output logic                 out_zero_division
);

  localparam logic signed [EXP_W-1:0] EXP_MAX_S = EXP_W'(FP_EXP_MAX);
  localparam logic signed [EXP_W-1:0] EXP_MIN_S = '0;

  logic       s1_valid_q, s2_valid_q;
  logic       s2_adv;
  s1_t        s1_q, s1_d;

  logic [IN_MANT_W-1:0] m_n;
  logic [EXP_W-1:0]     exp_sx, exp_n;
  logic [FP_SIG_W-1:0]  sig_r;
  logic                 carry_r, inexact_r;

  assign s2_adv   = !s2_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_adv;

  // ---------------- S1: normalise and round ----------------
  assign exp_sx = {in_exp[IN_EXP_W-1], in_exp};

  always_comb begin
    m_n   = in_mant;
    exp_n = exp_sx;
    if (!in_mant[IN_MANT_W-1]) begin
      m_n   = {in_mant[IN_MANT_W-2:0], 1'b0};
      exp_n = exp_sx - EXP_W'(1);
    end
  end

  fp_rne_round u_rne (
    .sig_i     (m_n[27:4]),
    .guard_i   (m_n[3]),
    .sticky_i  ((|m_n[2:0]) | in_sticky),
    .sig_o     (sig_r),
    .carry_o   (carry_r),
    .inexact_o (inexact_r)
  );

  always_comb begin
    s1_d          = '0;
    s1_d.sign     = in_sign;
    s1_d.exp      = exp_n;
    s1_d.sig      = sig_r;
    s1_d.carry    = carry_r;
    s1_d.inexact  = inexact_r;
    s1_d.nan      = in_nan;
    s1_d.zero_div = in_zero_div;
    s1_d.inf      = in_inf;
    s1_d.zero     = in_zero;
  end

  always_ff @(posedge clk) begin
    if (rst)           s1_valid_q <= 1'b0;
    else if (in_ready) s1_valid_q <= in_valid;
    if (in_valid && in_ready) s1_q <= s1_d;
  end

  // ---------------- S2: renormalise, range check, pack ----------------
  logic signed [EXP_W-1:0]  exp_f;
  logic [FP_FRAC_W-1:0]     frac_f;
  logic [31:0]              res_d;
  logic                     ovf_d, unf_d, inx_d, zd_d;

  // A carry out means the rounded sig is all zeros; shifting {1,sig} right
  // by one leaves 0x800000, whose fraction bits are sig[23:1].
  assign exp_f  = s1_q.exp + EXP_W'(s1_q.carry);
  assign frac_f = s1_q.carry ? s1_q.sig[FP_SIG_W-1:1] : s1_q.sig[FP_FRAC_W-1:0];

  always_comb begin
    res_d = {s1_q.sign, exp_f[FP_EXP_W-1:0], frac_f};
    ovf_d = 1'b0;
    unf_d = 1'b0;
    inx_d = s1_q.inexact;
    zd_d  = 1'b0;
    if (exp_f >= EXP_MAX_S) begin
      res_d = {s1_q.sign, 8'hFF, 23'h0};
      ovf_d = 1'b1;
      inx_d = 1'b1;
    end else if (exp_f <= EXP_MIN_S) begin
      res_d = {s1_q.sign, 31'h0};
      unf_d = 1'b1;
      inx_d = 1'b1;
    end
    if (s1_q.nan || s1_q.zero_div || s1_q.inf || s1_q.zero) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
      inx_d = 1'b0;
      if (s1_q.nan) begin
        res_d = FP_QNAN;
      end else if (s1_q.zero_div) begin
        res_d = {s1_q.sign, FP_POS_INF[30:0]};
        zd_d  = 1'b1;
      end else if (s1_q.inf) begin
        res_d = {s1_q.sign, FP_POS_INF[30:0]};
      end else begin
        res_d = {s1_q.sign, 31'h0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_q        <= 1'b0;
      out_result        <= '0;
      out_overflow      <= 1'b0;
      out_underflow     <= 1'b0;
      out_inexact       <= 1'b0;
      out_zero_division <= 1'b0;
    end else if (s2_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_result        <= res_d;
        out_overflow      <= ovf_d;
        out_underflow     <= unf_d;
        out_inexact       <= inx_d;
        out_zero_division <= zd_d;
      end
    end
  end

  assign out_valid = s2_valid_q;

endmodule
